// File: rtl/clksw_seq.sv
// Clock-switch sequencer: turns HS requests into a glitch-safe hsclk_sel level,
// waits for synchronised controller acknowledgements, enforces an HS dwell,
// times out stalled handovers and owns the CPU clock divider select.
module clksw_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DWELL       = 16,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [1:0]  DIV_RESET   = 2'b11
) (
  input  logic       hsclk_in,
  input  logic       rst_b,
  input  logic       req_hs,
  input  logic       force_ls,
  input  logic [1:0] div_sel_req,
  input  logic       err_clr,
  input  logic       hsclk_selected,
  input  logic       lsclk_selected,
  output logic       hsclk_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic       busy,
  output logic       hs_active,
  output logic       err
);

  typedef enum logic [1:0] {StToLs, StLs, StToHs, StHs} state_e;

  localparam logic [8:0] CntMax = 9'd511;

  state_e                 state_q, state_d;
  logic [8:0]             cnt_q, cnt_d;
  logic [1:0]             div_q, div_d;
  logic                   err_q, err_d;
  logic [SYNC_STAGES-1:0] hs_sync_q, ls_sync_q;
  logic                   hs_ack, ls_ack;
  logic                   err_set;

  assign hs_ack = hs_sync_q[SYNC_STAGES-1];
  assign ls_ack = ls_sync_q[SYNC_STAGES-1];

  // Acknowledge synchronisers, one chain per controller ack.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      hs_sync_q <= '0;
      ls_sync_q <= '0;
    end else begin
      hs_sync_q <= {hs_sync_q[SYNC_STAGES-2:0], hsclk_selected};
      ls_sync_q <= {ls_sync_q[SYNC_STAGES-2:0], lsclk_selected};
    end
  end

  // Next state, error set events and divider load.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    err_set = 1'b0;
    unique case (state_q)
      StToLs: begin
        if (ls_ack && !hs_ack) begin
          state_d = StLs;
        end else if (cnt_q == 9'(TIMEOUT)) begin
          // No safer state to fall back to, so keep waiting for LS.
          err_set = 1'b1;
        end
      end
      StLs: begin
        div_d = div_sel_req;
        if (req_hs && !force_ls) begin
          state_d = StToHs;
        end
      end
      StToHs: begin
        if (force_ls) begin
          state_d = StToLs;
        end else if (hs_ack && !ls_ack) begin
          state_d = StHs;
        end else if (cnt_q == 9'(TIMEOUT)) begin
          err_set = 1'b1;
          state_d = StToLs;
        end
      end
      StHs: begin
        if (force_ls) begin
          state_d = StToLs;
        end else if (!hs_ack) begin
          // Controller lost HS without being asked.
          err_set = 1'b1;
          state_d = StToLs;
        end else if (!req_hs && (cnt_q >= 9'(DWELL))) begin
          state_d = StToLs;
        end
      end
      default: state_d = StToLs;
    endcase
  end

  // Sticky error (set beats clear) and the shared state/dwell/timeout counter.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (err_set) begin
      err_d = 1'b1;
    end
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 9'd1;
    end
  end

  // State, counter, divider and error registers.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StToLs;
      cnt_q   <= '0;
      div_q   <= DIV_RESET;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded only from registered state, hence glitch-free.
  always_comb begin
    busy           = (state_q == StToLs) || (state_q == StToHs);
    hs_active      = (state_q == StHs);
    hsclk_sel      = (state_q == StToHs) || (state_q == StHs);
    cpuclk_div_sel = div_q;
    err            = err_q;
  end

endmodule
